// File: rtl/sensor_conditioner.sv
// Two-channel vehicle-detector conditioner: sync, debounce, presence hold and
// stuck-on fail-safe, producing the sen/fault pairs that feed tlc directly.

module sensor_conditioner_ch #(
   parameter int DEB_CYC   = 4,
   parameter int HOLD_CYC  = 8,
   parameter int STUCK_CYC = 1000,
   parameter int CW        = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   input  logic i_clr_fault,
   output logic o_sen,
   output logic o_fault
);

   typedef enum logic [2:0] {IDLE, QUAL, PRESENT, HOLD, FAULT} state_t;

   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYC - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_f1, r_f2;
   logic          r_sen, r_fault;

   // sen/fault are updated alongside the state so they stay pure Moore decodes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f1    <= 1'b0;
         r_f2    <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sen   <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_f1 <= i_raw;
         r_f2 <= r_f1;
         case (r_state)
            IDLE: begin
               if (r_f2) begin
                  if (DEB_CYC == 1) begin
                     r_state <= PRESENT;
                     r_cnt   <= '0;
                     r_sen   <= 1'b1;
                  end else begin
                     r_state <= QUAL;
                     r_cnt   <= CW'(1);
                  end
               end
            end
            QUAL: begin
               if (!r_f2) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state <= PRESENT;
                  r_cnt   <= '0;
                  r_sen   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            PRESENT: begin
               if (!r_f2) begin
                  r_state <= HOLD;
                  r_cnt   <= '0;
               end else if (r_cnt == STUCK_LAST) begin
                  r_state <= FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            HOLD: begin
               // a returning vehicle restarts the stuck count from zero
               if (r_f2) begin
                  r_state <= PRESENT;
                  r_cnt   <= '0;
               end else if (r_cnt == HOLD_LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_sen   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            FAULT: begin
               if (i_clr_fault && !r_f2) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_sen   <= 1'b0;
                  r_fault <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_sen   <= 1'b0;
               r_fault <= 1'b0;
            end
         endcase
      end
   end

   assign o_sen   = r_sen;
   assign o_fault = r_fault;

endmodule

module sensor_conditioner #(
   parameter int DEB_CYC   = 4,
   parameter int HOLD_CYC  = 8,
   parameter int STUCK_CYC = 1000,
   parameter int CW        = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw1,
   input  logic raw2,
   input  logic clr_fault,
   output logic sen1,
   output logic sen2,
   output logic fault1,
   output logic fault2
);

   localparam int NUM_LANES = 2;

   logic [NUM_LANES-1:0] w_raw, w_sen, w_fault;

   assign w_raw = {raw2, raw1};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
      sensor_conditioner_ch #(
         .DEB_CYC  (DEB_CYC),
         .HOLD_CYC (HOLD_CYC),
         .STUCK_CYC(STUCK_CYC),
         .CW       (CW)
      ) u_ch (
         .clk        (clk),
         .rst_n      (reset),
         .i_raw      (w_raw[g]),
         .i_clr_fault(clr_fault),
         .o_sen      (w_sen[g]),
         .o_fault    (w_fault[g])
      );
   end

   assign sen1   = w_sen[0];
   assign sen2   = w_sen[1];
   assign fault1 = w_fault[0];
   assign fault2 = w_fault[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: vector table plus hand sequences for
// stuck fault, fault clear and asynchronous reset.

module tb_sensor_conditioner;

   logic clk = 1'b0;
   logic reset, raw1, raw2, clr_fault;
   logic sen1, sen2, fault1, fault2;
   logic [3:0] w_out;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       r1, r2, clr;
      logic [3:0] exp, msk;   // {sen1, sen2, fault1, fault2}
   } vec_t;
   vec_t tbl[$];

   sensor_conditioner #(.DEB_CYC(4), .HOLD_CYC(8), .STUCK_CYC(20), .CW(16)) dut (
      .clk(clk), .reset(reset), .raw1(raw1), .raw2(raw2), .clr_fault(clr_fault),
      .sen1(sen1), .sen2(sen2), .fault1(fault1), .fault2(fault2)
   );

   always #10 clk = ~clk;
   assign w_out = {sen1, sen2, fault1, fault2};

   task automatic add(input logic r1, input logic r2, input logic clr,
                      input logic [3:0] exp, input logic [3:0] msk, input int n);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.clr = clr; v.exp = exp; v.msk = msk;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] exp, input logic [3:0] msk);
      n_chk++;
      if ((w_out & msk) !== (exp & msk)) begin
         n_fail++;
         $display("FAIL %s: got {sen1,sen2,f1,f2}=%b expected %b (mask %b)", nm, w_out, exp, msk);
      end
   endtask

   initial begin
      // A: release with both raw high; sen after edge DEB_CYC+1
      add(1,1,0, 4'b0000, 4'hF, 5);
      add(1,1,0, 4'b1100, 4'hF, 3);
      // B: both drop; hold for HOLD_CYC (edge m+9 left unchecked)
      add(0,0,0, 4'b1100, 4'hF, 9);
      add(0,0,0, 4'b0000, 4'b0011, 1);
      add(0,0,0, 4'b0000, 4'hF, 3);
      // C: 3-sample glitch rejected, then 4-sample pulse qualifies
      add(1,0,0, 4'b0000, 4'hF, 3);
      add(0,0,0, 4'b0000, 4'hF, 5);
      add(1,0,0, 4'b0000, 4'hF, 4);
      add(0,0,0, 4'b0000, 4'hF, 1);
      add(0,0,0, 4'b1000, 4'hF, 8);
      add(0,0,0, 4'b0000, 4'b0111, 1);
      add(0,0,0, 4'b0000, 4'hF, 3);
      // D: ch2 gap of 5 bridged; clr_fault outside FAULT is ignored
      add(0,1,0, 4'b0000, 4'hF, 5);
      add(0,1,0, 4'b0100, 4'hF, 5);
      add(0,0,1, 4'b0100, 4'hF, 5);
      add(0,1,0, 4'b0100, 4'hF, 10);
      add(0,0,0, 4'b0100, 4'hF, 9);
      add(0,0,0, 4'b0000, 4'b1011, 1);
      add(0,0,0, 4'b0000, 4'hF, 3);
      // E: 00,10,01,11,00,10 x5 cycles, then 00
      add(0,0,0, 4'b0000, 4'hF, 5);
      add(1,0,0, 4'b0000, 4'hF, 5);
      add(0,1,0, 4'b1000, 4'hF, 5);
      add(1,1,0, 4'b1100, 4'hF, 5);
      add(0,0,0, 4'b1100, 4'hF, 5);
      add(1,0,0, 4'b1100, 4'hF, 4);
      add(1,0,0, 4'b1000, 4'b1011, 1);
      add(0,0,0, 4'b1000, 4'hF, 9);
      add(0,0,0, 4'b0000, 4'b0111, 1);
      add(0,0,0, 4'b0000, 4'hF, 3);

      reset = 1'b0; raw1 = 1'b1; raw2 = 1'b1; clr_fault = 1'b0;
      #1 chk("reset_t0", 4'b0000, 4'hF);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset_hold%0d", i), 4'b0000, 4'hF);
      end
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         raw1 = tbl[i].r1; raw2 = tbl[i].r2; clr_fault = tbl[i].clr;
         tick();
         chk($sformatf("vec%0d", i), tbl[i].exp, tbl[i].msk);
      end
      clr_fault = 1'b0;

      // stuck fault on ch1, clear ignored while s=1, then cleared with s=0
      for (int k = 0; k < 45; k++) begin
         raw1 = (k < 40);
         raw2 = 1'b0;
         clr_fault = (k == 30) || (k == 41) || (k == 43);
         tick();
         if (k < 40)
            chk($sformatf("stuck%0d", k), {k >= 5, 1'b0, k >= 25, 1'b0}, 4'hF);
         else
            chk($sformatf("clear%0d", k), (k < 43) ? 4'b1010 : 4'b0000, 4'hF);
      end
      clr_fault = 1'b0;

      // ch1 mid-HOLD, ch2 mid-FAULT, then asynchronous reset
      for (int j = 0; j < 27; j++) begin
         raw1 = (j >= 10) && (j < 20);
         raw2 = 1'b1;
         tick();
         chk($sformatf("prerst%0d", j), {j >= 15, j >= 5, 1'b0, j >= 25}, 4'hF);
      end
      reset = 1'b0;
      #2 chk("reset_async", 4'b0000, 4'hF);
      tick();
      chk("reset_async_edge", 4'b0000, 4'hF);
      raw1 = 1'b0; raw2 = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst%0d", i), 4'b0000, 4'hF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
